// File: rtl/bus_mem_slave.sv
// Single-port 64-entry register-file slave executing one en/wr/addr access per cycle,
// with saturating access counters and a burst-length FSM.
module bus_mem_slave #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  burst_len,
  output logic              burst_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;

  state_t            state_q;
  logic [CNT_W-1:0]  run_q;
  logic [CNT_W-1:0]  burst_len_q;
  logic              burst_done_q;

  logic do_wr, do_rd;
  assign do_wr = en &&  wr;
  assign do_rd = en && !wr;

  // NOTE: the storage must read back as zero after reset, so every word is
  // cleared; this keeps it in flops rather than a RAM macro, which is fine at 64 words.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_wr) begin
      mem_q[addr] <= wdata;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (do_rd) begin
      rdata_d  = mem_q[addr];
      rvalid_d = 1'b1;
      if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + CNT_W'(1);
    end
    if (do_wr && wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // Burst tracker: run counts enabled cycles; a burst ends on the first idle edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      run_q        <= '0;
      burst_len_q  <= '0;
      burst_done_q <= 1'b0;
    end else begin
      burst_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en) begin
            state_q <= ACTIVE;
            run_q   <= CNT_W'(1);
          end
        end
        ACTIVE: begin
          if (en) begin
            if (run_q != '1) run_q <= run_q + CNT_W'(1);
          end else begin
            burst_len_q  <= run_q;
            burst_done_q <= 1'b1;
            state_q      <= IDLE;
            run_q        <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          run_q   <= '0;
        end
      endcase
    end
  end

  assign rdata      = rdata_q;
  assign rvalid     = rvalid_q;
  assign wr_cnt     = wr_cnt_q;
  assign rd_cnt     = rd_cnt_q;
  assign burst_len  = burst_len_q;
  assign burst_done = burst_done_q;

endmodule

// File: tb/tb_bus_mem_slave.sv
// Directed bench for bus_mem_slave: a default build plus a CNT_W=4 build for saturation,
// both driven by the same bus.
module tb_bus_mem_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       wr = 1'b0;
  logic [5:0] addr = '0;
  logic [7:0] wdata = '0;

  logic [7:0]  rdata;
  logic        rvalid;
  logic [15:0] wr_cnt, rd_cnt, burst_len;
  logic        burst_done;

  logic [7:0] s_rdata;
  logic       s_rvalid;
  logic [3:0] s_wr_cnt, s_rd_cnt, s_burst_len;
  logic       s_burst_done;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  bus_mem_slave dut (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rvalid(rvalid), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt),
    .burst_len(burst_len), .burst_done(burst_done)
  );

  bus_mem_slave #(.DATA_W(8), .ADDR_W(6), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(s_rdata), .rvalid(s_rvalid), .wr_cnt(s_wr_cnt), .rd_cnt(s_rd_cnt),
    .burst_len(s_burst_len), .burst_done(s_burst_done)
  );

  // Drive between edges, then return just after the edge that samples the bus.
  task automatic step(input logic r, input logic e, input logic w,
                      input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    rst = r; en = e; wr = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step(1'b0, 1'b1, 1'b1, 6'd5, 8'hAA);
    step(1'b0, 1'b1, 1'b0, 6'd5, 8'h00);
    vectors++;
    if (rdata !== 8'hAA) begin
      $display("FAIL reset_preload rdata got %h want aa", rdata); errors++;
    end
    step(1'b1, 1'b0, 1'b0, 6'd0, 8'h00);
    vectors++;
    if ({rdata, rvalid, wr_cnt, rd_cnt, burst_len, burst_done} !== '0) begin
      $display("FAIL reset_outputs rdata=%h rvalid=%b wr=%0d rd=%0d len=%0d done=%b want all 0",
               rdata, rvalid, wr_cnt, rd_cnt, burst_len, burst_done);
      errors++;
    end
    step(1'b0, 1'b1, 1'b0, 6'd5, 8'h00);
    vectors++;
    if (rdata !== 8'h00 || rvalid !== 1'b1) begin
      $display("FAIL reset_mem_clear rdata=%h rvalid=%b want 00/1", rdata, rvalid); errors++;
    end
    step(1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
  endtask

  task automatic test_write_read_burst;
    logic [5:0] addrs [5] = '{6'd12, 6'd14, 6'd23, 6'd12, 6'd14};
    logic [7:0] datas [5] = '{8'h11, 8'h22, 8'h00, 8'h00, 8'h00};
    logic [7:0] exp_rd [5] = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
    step(1'b1, 1'b0, 1'b0, 6'd0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, (i < 2), addrs[i], datas[i]);
      vectors++;
      if (i >= 2 && (rdata !== exp_rd[i] || rvalid !== 1'b1)) begin
        $display("FAIL burst_read[%0d] rdata=%h rvalid=%b want %h/1", i, rdata, rvalid, exp_rd[i]);
        errors++;
      end else if (i < 2 && (rvalid !== 1'b0 || wr_cnt !== 16'(i + 1))) begin
        $display("FAIL burst_write[%0d] rvalid=%b wr_cnt=%0d want 0/%0d", i, rvalid, wr_cnt, i + 1);
        errors++;
      end
      vectors++;
      if (burst_done !== 1'b0) begin
        $display("FAIL burst_done_early[%0d] got %b want 0", i, burst_done); errors++;
      end
    end
    step(1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
    vectors++;
    if (burst_done !== 1'b1 || burst_len !== 16'd5 || wr_cnt !== 16'd2 || rd_cnt !== 16'd3) begin
      $display("FAIL burst_end done=%b len=%0d wr=%0d rd=%0d want 1/5/2/3",
               burst_done, burst_len, wr_cnt, rd_cnt);
      errors++;
    end
    vectors++;
    if (rvalid !== 1'b0 || rdata !== 8'h22) begin
      $display("FAIL idle_hold rvalid=%b rdata=%h want 0/22", rvalid, rdata); errors++;
    end
    step(1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
    vectors++;
    if (burst_done !== 1'b0 || burst_len !== 16'd5) begin
      $display("FAIL burst_pulse_once done=%b len=%0d want 0/5", burst_done, burst_len); errors++;
    end
  endtask

  task automatic test_read_after_write;
    step(1'b0, 1'b1, 1'b1, 6'd48, 8'h5C);
    step(1'b0, 1'b1, 1'b0, 6'd48, 8'h00);
    vectors++;
    if (rdata !== 8'h5C || rvalid !== 1'b1) begin
      $display("FAIL raw rdata=%h rvalid=%b want 5c/1", rdata, rvalid); errors++;
    end
    step(1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
  endtask

  task automatic test_gap;
    step(1'b0, 1'b1, 1'b0, 6'd0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 6'd1, 8'h33);
    step(1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
    vectors++;
    if (burst_done !== 1'b1 || burst_len !== 16'd2) begin
      $display("FAIL gap_first done=%b len=%0d want 1/2", burst_done, burst_len); errors++;
    end
    step(1'b0, 1'b1, 1'b0, 6'd1, 8'h00);
    step(1'b0, 1'b1, 1'b1, 6'd2, 8'h44);
    vectors++;
    if (burst_done !== 1'b0 || burst_len !== 16'd2) begin
      $display("FAIL gap_mid done=%b len=%0d want 0/2", burst_done, burst_len); errors++;
    end
    step(1'b0, 1'b1, 1'b0, 6'd2, 8'h00);
    vectors++;
    if (rdata !== 8'h44) begin
      $display("FAIL gap_read rdata=%h want 44", rdata); errors++;
    end
    step(1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
    vectors++;
    if (burst_done !== 1'b1 || burst_len !== 16'd3) begin
      $display("FAIL gap_second done=%b len=%0d want 1/3", burst_done, burst_len); errors++;
    end
  endtask

  task automatic test_reset_mid_burst;
    step(1'b0, 1'b1, 1'b1, 6'd6, 8'h77);
    step(1'b0, 1'b1, 1'b0, 6'd6, 8'h00);
    step(1'b1, 1'b1, 1'b1, 6'd7, 8'h99);
    vectors++;
    if (burst_done !== 1'b0 || burst_len !== 16'd0 || wr_cnt !== 16'd0 || rd_cnt !== 16'd0) begin
      $display("FAIL midrst_state done=%b len=%0d wr=%0d rd=%0d want 0/0/0/0",
               burst_done, burst_len, wr_cnt, rd_cnt);
      errors++;
    end
    step(1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
    vectors++;
    if (burst_done !== 1'b0 || burst_len !== 16'd0) begin
      $display("FAIL midrst_no_done done=%b len=%0d want 0/0", burst_done, burst_len); errors++;
    end
    step(1'b0, 1'b1, 1'b0, 6'd7, 8'h00);
    vectors++;
    if (rdata !== 8'h00 || rd_cnt !== 16'd1 || wr_cnt !== 16'd0) begin
      $display("FAIL midrst_write_blocked rdata=%h rd=%0d wr=%0d want 00/1/0", rdata, rd_cnt, wr_cnt);
      errors++;
    end
    step(1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
    vectors++;
    if (burst_done !== 1'b1 || burst_len !== 16'd1) begin
      $display("FAIL midrst_idle_restart done=%b len=%0d want 1/1", burst_done, burst_len); errors++;
    end
  endtask

  task automatic test_saturation;
    step(1'b1, 1'b0, 1'b0, 6'd0, 8'h00);
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 1'b1, 1'b0, 6'(k), 8'h00);
      vectors++;
      if (s_rd_cnt !== 4'((k > 15) ? 15 : k) || rd_cnt !== 16'(k)) begin
        $display("FAIL sat_rd_cnt[%0d] small=%0d big=%0d want %0d/%0d",
                 k, s_rd_cnt, rd_cnt, (k > 15) ? 15 : k, k);
        errors++;
      end
    end
    step(1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
    vectors++;
    if (s_burst_done !== 1'b1 || s_burst_len !== 4'd15 || s_rd_cnt !== 4'd15) begin
      $display("FAIL sat_burst done=%b len=%0d rd=%0d want 1/15/15", s_burst_done, s_burst_len, s_rd_cnt);
      errors++;
    end
    vectors++;
    if (burst_len !== 16'd20 || s_wr_cnt !== 4'd0) begin
      $display("FAIL sat_wide_len len=%0d small_wr=%0d want 20/0", burst_len, s_wr_cnt); errors++;
    end
  endtask

  initial begin
    step(1'b1, 1'b0, 1'b0, 6'd0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 6'd0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
    test_reset;
    test_write_read_burst;
    test_read_after_write;
    test_gap;
    test_reset_mid_burst;
    test_saturation;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
